// File: rtl/id_ex_stage_if.sv
// ID/EX stage port bundle: decoded instruction, forwarding sources and EX-side outputs.
// "master" is the surrounding pipeline; "slave" is the stage itself.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic [REG_AW-1:0] rd_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [15:0]       imm16;
  logic              ex_fwd_en;
  logic [REG_AW-1:0] ex_fwd_addr;
  logic [DATA_W-1:0] ex_fwd_data;
  logic              mem_fwd_en;
  logic [REG_AW-1:0] mem_fwd_addr;
  logic [DATA_W-1:0] mem_fwd_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [3:0]        ALU_Sel;
  logic [REG_AW-1:0] dest_addr;
  logic              reg_write;
  logic              illegal;

  modport master (
    output in_valid, opcode, funct, rs_addr, rt_addr, rd_addr, rs_data, rt_data, imm16,
           ex_fwd_en, ex_fwd_addr, ex_fwd_data, mem_fwd_en, mem_fwd_addr, mem_fwd_data,
           flush, out_ready,
    input  in_ready, out_valid, A, B, ALU_Sel, dest_addr, reg_write, illegal
  );

  modport slave (
    input  in_valid, opcode, funct, rs_addr, rt_addr, rd_addr, rs_data, rt_data, imm16,
           ex_fwd_en, ex_fwd_addr, ex_fwd_data, mem_fwd_en, mem_fwd_addr, mem_fwd_data,
           flush, out_ready,
    output in_ready, out_valid, A, B, ALU_Sel, dest_addr, reg_write, illegal
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes opcode/funct into ALU_Sel, resolves forwarded
// operands and holds A/B/ALU_Sel/writeback control behind a valid/ready handshake.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);
  logic              is_r;
  logic              dec_legal;
  logic [3:0]        dec_sel;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rs_op;
  logic [DATA_W-1:0] rt_op;
  logic [REG_AW-1:0] dec_dest;
  logic              capture;

  logic              valid_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [3:0]        sel_q;
  logic [REG_AW-1:0] dest_q;
  logic              wr_q;
  logic              ill_q;

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

  // Unsupported encodings fall back to AND (select 4) with no writeback.
  always_comb begin
    is_r      = (bus.opcode == 6'h00);
    dec_sel   = 4'd4;
    dec_legal = 1'b1;
    if (is_r) begin
      case (bus.funct)
        6'h20:   dec_sel = 4'd0;
        6'h21:   dec_sel = 4'd1;
        6'h22:   dec_sel = 4'd2;
        6'h23:   dec_sel = 4'd3;
        6'h24:   dec_sel = 4'd4;
        6'h25:   dec_sel = 4'd5;
        6'h26:   dec_sel = 4'd6;
        6'h2A:   dec_sel = 4'd8;
        6'h2B:   dec_sel = 4'd7;
        default: dec_legal = 1'b0;
      endcase
    end else begin
      case (bus.opcode)
        6'h08:   dec_sel = 4'd0;
        6'h09:   dec_sel = 4'd1;
        6'h0A:   dec_sel = 4'd8;
        6'h0B:   dec_sel = 4'd7;
        6'h0C:   dec_sel = 4'd4;
        6'h0D:   dec_sel = 4'd5;
        6'h0E:   dec_sel = 4'd6;
        default: dec_legal = 1'b0;
      endcase
    end
  end

  // Logical immediates are zero-extended; everything else sign-extends.
  always_comb begin
    if (bus.opcode == 6'h0C || bus.opcode == 6'h0D || bus.opcode == 6'h0E)
      imm_ext = {{(DATA_W-16){1'b0}}, bus.imm16};
    else
      imm_ext = {{(DATA_W-16){bus.imm16[15]}}, bus.imm16};
    dec_dest = is_r ? bus.rd_addr : bus.rt_addr;
  end

  // Register zero is never forwarded; the younger EX/MEM result wins over MEM/WB.
  always_comb begin
    rs_op = bus.rs_data;
    if (bus.rs_addr != '0) begin
      if (bus.ex_fwd_en && bus.ex_fwd_addr == bus.rs_addr)
        rs_op = bus.ex_fwd_data;
      else if (bus.mem_fwd_en && bus.mem_fwd_addr == bus.rs_addr)
        rs_op = bus.mem_fwd_data;
    end
    rt_op = bus.rt_data;
    if (bus.rt_addr != '0) begin
      if (bus.ex_fwd_en && bus.ex_fwd_addr == bus.rt_addr)
        rt_op = bus.ex_fwd_data;
      else if (bus.mem_fwd_en && bus.mem_fwd_addr == bus.rt_addr)
        rt_op = bus.mem_fwd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      dest_q  <= '0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      a_q     <= rs_op;
      b_q     <= is_r ? rt_op : imm_ext;
      sel_q   <= dec_sel;
      dest_q  <= dec_dest;
      wr_q    <= dec_legal && (dec_dest != '0);
      ill_q   <= !dec_legal;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.ALU_Sel   = sel_q;
  assign bus.dest_addr = dest_q;
  assign bus.reg_write = wr_q;
  assign bus.illegal   = ill_q;
endmodule
